// File: rtl/core_shift_issue_pkg.sv
// Shared operand-2 / barrel-shifter interface types for the ARM data-processing path.
package core_shift_issue_pkg;

  typedef struct packed {
    logic ror;
    logic shr;
    logic sign_extend;
    logic put_carry;
  } shifter_control;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'd0,
    SHIFT_LSR = 2'd1,
    SHIFT_ASR = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_type_t;

  typedef enum logic [1:0] {
    OP2_IMM       = 2'd0,
    OP2_SHIFT_IMM = 2'd1,
    OP2_SHIFT_REG = 2'd2
  } shift_kind_t;

  localparam logic [7:0] SHIFT_RRX_AMT    = 8'd1;
  localparam logic [7:0] SHIFT_ZERO_AS_32 = 8'd32;

endpackage

// File: rtl/core_shift_issue_resolve.sv
// Combinational decode of an ARM operand-2 encoding into a barrel-shifter request.
module core_shift_resolve
  import core_shift_issue_pkg::*;
#(
  parameter int W = 32
) (
  input  shift_kind_t    kind_i,
  input  shift_type_t    type_i,
  input  logic [7:0]     amt_i,
  input  logic [7:0]     imm8_i,
  input  logic [3:0]     rot_i,
  input  logic [W-1:0]   rm_i,
  input  logic           c_i,
  output shifter_control ctrl_o,
  output logic [W-1:0]   base_o,
  output logic [7:0]     shift_o,
  output logic           c_in_o
);

  always_comb begin
    ctrl_o  = '0;
    base_o  = rm_i;
    shift_o = amt_i;
    c_in_o  = c_i;
    case (kind_i)
      OP2_SHIFT_IMM: begin
        // Immediate #0 is an alias: LSR/ASR mean #32, ROR means RRX.
        case (type_i)
          SHIFT_LSR: begin
            ctrl_o.shr = 1'b1;
            if (amt_i == 8'd0) shift_o = SHIFT_ZERO_AS_32;
          end
          SHIFT_ASR: begin
            ctrl_o.shr         = 1'b1;
            ctrl_o.sign_extend = 1'b1;
            if (amt_i == 8'd0) shift_o = SHIFT_ZERO_AS_32;
          end
          SHIFT_ROR: begin
            if (amt_i == 8'd0) begin
              ctrl_o.shr       = 1'b1;
              ctrl_o.put_carry = 1'b1;
              shift_o          = SHIFT_RRX_AMT;
            end else begin
              ctrl_o.ror = 1'b1;
            end
          end
          default: ctrl_o = '0;
        endcase
      end
      OP2_SHIFT_REG: begin
        case (type_i)
          SHIFT_LSR: ctrl_o.shr = 1'b1;
          SHIFT_ASR: begin
            ctrl_o.shr         = 1'b1;
            ctrl_o.sign_extend = 1'b1;
          end
          SHIFT_ROR: ctrl_o.ror = 1'b1;
          default:   ctrl_o = '0;
        endcase
      end
      default: begin
        base_o     = {{(W-8){1'b0}}, imm8_i};
        ctrl_o.ror = 1'b1;
        shift_o    = {3'b000, rot_i, 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/core_shift_issue.sv
// Operand-2 sequencer: resolves shift encodings, fetches Rs when needed and issues
// one registered valid/ready request to the shifter stage.
module core_shift_issue
  import core_shift_issue_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           op_valid,
  output logic           op_ready,
  input  shift_kind_t    op_kind,
  input  shift_type_t    op_type,
  input  logic [7:0]     op_imm8,
  input  logic [3:0]     op_rot,
  input  logic [4:0]     op_amt,
  input  logic [W-1:0]   op_rm,
  input  logic [3:0]     op_rs,
  input  logic           c_flag,
  output logic           rs_req,
  output logic [3:0]     rs_addr,
  input  logic [W-1:0]   rs_data,
  output logic           out_valid,
  input  logic           out_ready,
  output shifter_control out_ctrl,
  output logic [W-1:0]   out_base,
  output logic [7:0]     out_shift,
  output logic           out_c_in
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RS_REQ  = 2'd1;
  localparam logic [1:0] RS_DATA = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  logic [1:0]     state_q, state_d;
  shift_type_t    type_q, type_d;
  logic [W-1:0]   rm_q, rm_d;
  logic           c_q, c_d;
  logic [3:0]     rs_addr_q, rs_addr_d;
  logic           valid_q, valid_d;
  shifter_control ctrl_q, ctrl_d;
  logic [W-1:0]   base_q, base_d;
  logic [7:0]     shift_q, shift_d;
  logic           cin_q, cin_d;

  logic           from_rs;
  logic           accept;
  shift_kind_t    res_kind;
  shift_type_t    res_type;
  logic [7:0]     res_amt;
  logic [W-1:0]   res_rm;
  logic           res_c;
  shifter_control res_ctrl;
  logic [W-1:0]   res_base;
  logic [7:0]     res_shift;
  logic           res_c_in;
  logic           unused_rs_hi;

  // One resolver serves both the direct path and the Rs-return path.
  assign from_rs  = (state_q == RS_DATA);
  assign res_kind = from_rs ? OP2_SHIFT_REG : op_kind;
  assign res_type = from_rs ? type_q : op_type;
  assign res_amt  = from_rs ? rs_data[7:0] : {3'b000, op_amt};
  assign res_rm   = from_rs ? rm_q : op_rm;
  assign res_c    = from_rs ? c_q : c_flag;
  assign unused_rs_hi = ^rs_data[W-1:8];

  core_shift_resolve #(.W(W)) u_resolve (
    .kind_i  (res_kind),
    .type_i  (res_type),
    .amt_i   (res_amt),
    .imm8_i  (op_imm8),
    .rot_i   (op_rot),
    .rm_i    (res_rm),
    .c_i     (res_c),
    .ctrl_o  (res_ctrl),
    .base_o  (res_base),
    .shift_o (res_shift),
    .c_in_o  (res_c_in)
  );

  assign op_ready = !flush && ((state_q == IDLE) || ((state_q == OUT) && out_ready));
  assign accept   = op_valid && op_ready;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    rm_d      = rm_q;
    c_d       = c_q;
    rs_addr_d = rs_addr_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    base_d    = base_q;
    shift_d   = shift_q;
    cin_d     = cin_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        RS_REQ: state_d = RS_DATA;
        RS_DATA: begin
          ctrl_d  = res_ctrl;
          base_d  = res_base;
          shift_d = res_shift;
          cin_d   = res_c_in;
          valid_d = 1'b1;
          state_d = OUT;
        end
        default: begin
          // IDLE or OUT: retire the current request, then possibly take a new one.
          if ((state_q == OUT) && out_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
          if (accept) begin
            if (op_kind == OP2_SHIFT_REG) begin
              type_d    = op_type;
              rm_d      = op_rm;
              c_d       = c_flag;
              rs_addr_d = op_rs;
              valid_d   = 1'b0;
              state_d   = RS_REQ;
            end else begin
              ctrl_d  = res_ctrl;
              base_d  = res_base;
              shift_d = res_shift;
              cin_d   = res_c_in;
              valid_d = 1'b1;
              state_d = OUT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      type_q    <= SHIFT_LSL;
      rm_q      <= '0;
      c_q       <= 1'b0;
      rs_addr_q <= '0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      base_q    <= '0;
      shift_q   <= '0;
      cin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      rm_q      <= rm_d;
      c_q       <= c_d;
      rs_addr_q <= rs_addr_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      base_q    <= base_d;
      shift_q   <= shift_d;
      cin_q     <= cin_d;
    end
  end

  assign rs_req    = (state_q == RS_REQ);
  assign rs_addr   = rs_addr_q;
  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_base  = base_q;
  assign out_shift = shift_q;
  assign out_c_in  = cin_q;

endmodule

// File: doc/core_shift_issue.md
Name: core_shift_issue

Overview:
- Operand-2 sequencer for the ARM data-processing path; it is the driving end of the barrel shifter interface.
- Accepts a decoded operand-2 descriptor and resolves ARM shift encodings into a shifter_control word plus base, shift and c_in. Resolved encodings: rotated immediate, immediate shift, register-specified shift, LSR/ASR #0 meaning #32, ROR #0 meaning RRX.
- Sequences the extra register-file read that register-specified shifts need.
- Presents one registered, valid/ready-handshaked request to the shifter stage.

Parameters:
- W, 32, datapath width; must be a power of two and at least 8.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; drops any in-flight op.
- op_valid  in  1  descriptor valid.
- op_ready  out  1  descriptor accepted when op_valid && op_ready.
- op_kind  in  2  operand-2 kind: OP2_IMM, OP2_SHIFT_IMM, OP2_SHIFT_REG (shift_kind_t).
- op_type  in  2  shift type LSL=0, LSR=1, ASR=2, ROR=3 (shift_type_t).
- op_imm8  in  8  immediate byte (OP2_IMM).
- op_rot  in  4  rotate field (OP2_IMM).
- op_amt  in  5  immediate shift amount (OP2_SHIFT_IMM).
- op_rm  in  W  Rm value, already read.
- op_rs  in  4  Rs index (OP2_SHIFT_REG).
- c_flag  in  1  current CPSR C, sampled at accept.
- rs_req  out  1  register-file read strobe.
- rs_addr  out  4  register-file read index.
- rs_data  in  W  read data, valid exactly one cycle after rs_req.
- out_valid  out  1  shifter request valid.
- out_ready  in  1  shifter stage accepts.
- out_ctrl  out  shifter_control  fields ror, shr, sign_extend, put_carry.
- out_base  out  W  shifter base operand.
- out_shift  out  8  shift amount.
- out_c_in  out  1  carry into the shifter.

Behaviour:
- Reset (async, rst_n low): state=IDLE. out_valid=0, rs_req=0, rs_addr=0, out_ctrl=all 0, out_base=0, out_shift=0, out_c_in=0.
- FSM states: IDLE, RS_REQ, RS_DATA, OUT.
- Handshake:
  - op_ready = (state==IDLE) || (state==OUT && out_ready); never asserted during RS_REQ or RS_DATA.
  - All out_* are registered and held stable while out_valid && !out_ready.
- Accept with op_kind != OP2_SHIFT_REG: outputs are loaded directly and state goes to OUT. out_valid rises the cycle after accept (latency 1).
- Accept with OP2_SHIFT_REG:
  - Latch op_type, op_rm and c_flag; go to RS_REQ.
  - RS_REQ: rs_req=1, rs_addr=op_rs; then go to RS_DATA.
  - RS_DATA: rs_data is captured; shift=rs_data[7:0] and outputs are loaded; go to OUT. out_valid rises 3 cycles after accept.
- OUT with out_ready: return to IDLE, or load the next op if op_valid, giving back-to-back issue with no bubble.
- Resolution rules (c_in=latched C unless stated; put_carry=0 unless stated):
  - OP2_IMM: base = zero-extended imm8; ror=1; shift = {op_rot,1'b0}. With rot=0 the carry-out equals C.
  - OP2_SHIFT_IMM, LSL: shr=0, shift=amt; amt=0 passes base and C unchanged.
  - OP2_SHIFT_IMM, LSR: shr=1, shift = amt, or 32 when amt=0.
  - OP2_SHIFT_IMM, ASR: shr=1, sign_extend=1, shift = amt, or 32 when amt=0.
  - OP2_SHIFT_IMM, ROR, amt!=0: ror=1, shift=amt.
  - OP2_SHIFT_IMM, ROR, amt=0 (RRX): shr=1, put_carry=1, shift=1.
  - OP2_SHIFT_REG: ctrl is as for an immediate of the same type but with no #0 remapping. shift = Rs[7:0] verbatim, values ≥32 included. Amount 0 passes base and C unchanged.
- flush: synchronous, highest priority after reset. Any state goes to IDLE, out_valid=0, rs_req=0. An op offered in the same cycle is not accepted (op_ready=0 while flush).
- Reset mid-operation: aborts any state immediately, including a pending register read; rs_data is ignored.
- Width rule: shift values 32 and up use the full 8 bits; the shifter owns ≥W semantics.

Decomposition:
- Shared package core/uarch.sv holds:
  - shifter_control (existing);
  - new enums shift_type_t and shift_kind_t;
  - constant SHIFT_RRX_AMT=1.
- One natural sub-module: core_shift_resolve, a combinational map from (kind, type, amount, imm8, rot, rm, c) to (ctrl, base, shift, c_in). It is shared by the immediate path and the RS_DATA path.

Test Plan:
- Rotated immediate: OP2_IMM, imm8=0xFF, rot=4, C=0 -> one cycle later out_valid=1, base=0x000000FF, ror=1, shift=8, c_in=0.
- LSR #0: OP2_SHIFT_IMM LSR amt=0, rm=0x80000000 -> shr=1, sign_extend=0, shift=32. ASR #0 with the same rm -> shift=32, sign_extend=1.
- RRX: ROR amt=0, rm=0x00000003, C=1 -> shr=1, put_carry=1, shift=1, c_in=1.
- Register shift: OP2_SHIFT_REG LSL, rs=5, rs_data=0x00000121 -> rs_req=1 and rs_addr=5 at accept+1; shift=0x21, out_valid at accept+3; op_ready=0 for those cycles.
- Backpressure and back-to-back: hold out_ready=0 for 4 cycles -> outputs stable and op_ready=0. Then out_ready=1 with a new op_valid -> accepted the same cycle, new outputs the next cycle, no bubble.
- Flush and reset: flush in RS_DATA -> next cycle IDLE, out_valid=0, no issue. rst_n low in OUT -> out_valid=0 immediately (asynchronous).
